// File: rtl/usb_reset_ctrl.sv
`timescale 1ns/1ps
// usb_reset_ctrl
//   Reset and attach sequencer for the USB bootloader core. Holds the core in
//   reset until the PLL has been locked and stable, enables the D+ pull-up a
//   fixed time after the core leaves reset, and re-resets the core whenever
//   the host signals a USB bus reset (prolonged SE0 on the received line).
//
// Ports
//   clk_48mhz        in   1  only clock (PLL output)
//   reset            in   1  synchronous, active-high
//   pll_lock         in   1  PLL lock, asynchronous (synchronized here)
//   usb_p_rx         in   1  received D+, asynchronous (synchronized here)
//   usb_n_rx         in   1  received D-, asynchronous (synchronized here)
//   usb_tx_en        in   1  core transmit enable, synchronous to clk_48mhz
//   core_reset       out  1  reset for the bootloader core
//   pu_en            out  1  D+ pull-up enable
//   bus_reset_count  out  8  number of bus resets seen, saturating at 255
module usb_reset_ctrl #(
    parameter int LOCK_STABLE_CYCLES  = 4800,
    parameter int ATTACH_DELAY_CYCLES = 48000,
    parameter int SE0_RESET_CYCLES    = 120,
    parameter int RESET_HOLD_CYCLES   = 48
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    input  logic       usb_tx_en,
    output logic       core_reset,
    output logic       pu_en,
    output logic [7:0] bus_reset_count
);

    // One counter is shared by every timed state, so it is sized for the
    // largest interval.
    localparam int MAX_AB = (LOCK_STABLE_CYCLES > ATTACH_DELAY_CYCLES) ?
                            LOCK_STABLE_CYCLES : ATTACH_DELAY_CYCLES;
    localparam int MAX_CD = (SE0_RESET_CYCLES > RESET_HOLD_CYCLES) ?
                            SE0_RESET_CYCLES : RESET_HOLD_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ATTACH_LAST = CNT_W'(ATTACH_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SE0_LAST    = CNT_W'(SE0_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        WAIT_LOCK   = 3'd0,
        LOCK_STABLE = 3'd1,
        ATTACH_WAIT = 3'd2,
        ATTACHED    = 3'd3,
        BUS_RESET   = 3'd4,
        HOLD        = 3'd5
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic holds_core_reset(input state_t s);
        return (s == WAIT_LOCK) || (s == LOCK_STABLE) ||
               (s == BUS_RESET) || (s == HOLD);
    endfunction

    function automatic logic drives_pullup(input state_t s);
        return (s == ATTACHED) || (s == BUS_RESET) || (s == HOLD);
    endfunction

    // Two-flop synchronizers; bit 1 is the synchronized value.
    logic [1:0] lock_sync_q;
    logic [1:0] p_sync_q;
    logic [1:0] n_sync_q;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            lock_sync_q <= 2'b00;
            p_sync_q    <= 2'b00;
            n_sync_q    <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_lock};
            p_sync_q    <= {p_sync_q[0], usb_p_rx};
            n_sync_q    <= {n_sync_q[0], usb_n_rx};
        end
    end

    logic lock_s;
    logic se0;

    assign lock_s = lock_sync_q[1];
    // The core's own EOP drives SE0 while transmitting; mask it out.
    assign se0    = !p_sync_q[1] && !n_sync_q[1] && !usb_tx_en;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       brc_q, brc_d;
    logic             core_reset_q;
    logic             pu_en_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        brc_d   = brc_q;
        // Losing lock overrides every other transition.
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_d = '0;
                    if (lock_s) begin
                        state_d = LOCK_STABLE;
                    end
                end
                LOCK_STABLE: begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d = ATTACH_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ATTACH_WAIT: begin
                    if (cnt_q == ATTACH_LAST) begin
                        state_d = ATTACHED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ATTACHED: begin
                    if (!se0) begin
                        cnt_d = '0;
                    end else if (cnt_q == SE0_LAST) begin
                        state_d = BUS_RESET;
                        cnt_d   = '0;
                        brc_d   = sat_inc8(brc_q);
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                BUS_RESET: begin
                    cnt_d = '0;
                    if (!se0) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    // SE0 coming back is the same bus reset, not a new one.
                    if (se0) begin
                        state_d = BUS_RESET;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ATTACHED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch together with
    // the state register.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            brc_q        <= 8'd0;
            core_reset_q <= 1'b1;
            pu_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            brc_q        <= brc_d;
            core_reset_q <= holds_core_reset(state_d);
            pu_en_q      <= drives_pullup(state_d);
        end
    end

    assign core_reset      = core_reset_q;
    assign pu_en           = pu_en_q;
    assign bus_reset_count = brc_q;

endmodule

// File: tb/tb_usb_reset_ctrl.sv
`timescale 1ns/1ps
module tb_usb_reset_ctrl;

    localparam int L = 8;
    localparam int A = 16;
    localparam int S = 10;
    localparam int H = 4;

    localparam logic [1:0] CR_RISE = 2'd0;
    localparam logic [1:0] CR_FALL = 2'd1;
    localparam logic [1:0] PU_RISE = 2'd2;
    localparam logic [1:0] PU_FALL = 2'd3;

    // Reference-model phases, described by what the line and PLL have done.
    localparam int PH_NOLOCK  = 0;
    localparam int PH_SETTLE  = 1;
    localparam int PH_DELAY   = 2;
    localparam int PH_LIVE    = 3;
    localparam int PH_BUSRST  = 4;
    localparam int PH_RECOVER = 5;

    typedef struct packed {
        logic       cr;
        logic       pu;
        logic [7:0] cnt;
    } exp_t;

    typedef struct packed {
        logic [1:0] kind;
        int         at;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic pll_lock;
    logic p_rx;
    logic n_rx;
    logic tx_en;
    logic core_reset;
    logic pu_en;
    logic [7:0] bus_reset_count;

    always #5 clk = ~clk;

    usb_reset_ctrl #(
        .LOCK_STABLE_CYCLES (L),
        .ATTACH_DELAY_CYCLES(A),
        .SE0_RESET_CYCLES   (S),
        .RESET_HOLD_CYCLES  (H)
    ) dut (
        .clk_48mhz      (clk),
        .reset          (rst),
        .pll_lock       (pll_lock),
        .usb_p_rx       (p_rx),
        .usb_n_rx       (n_rx),
        .usb_tx_en      (tx_en),
        .core_reset     (core_reset),
        .pu_en          (pu_en),
        .bus_reset_count(bus_reset_count)
    );

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    exp_t sb_q[$];
    ev_t  ev_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    int         m_ph = PH_NOLOCK;
    int         m_age = 0;
    int         m_resets = 0;
    logic [1:0] m_lock_hist = 2'b00;
    logic [1:0] m_p_hist = 2'b00;
    logic [1:0] m_n_hist = 2'b00;

    task automatic model_step();
        logic lock_seen;
        logic se0_seen;
        exp_t e;
        lock_seen = m_lock_hist[1];
        se0_seen  = !m_p_hist[1] && !m_n_hist[1] && !tx_en;
        if (rst) begin
            m_ph        = PH_NOLOCK;
            m_age       = 0;
            m_resets    = 0;
            m_lock_hist = 2'b00;
            m_p_hist    = 2'b00;
            m_n_hist    = 2'b00;
        end else begin
            if (m_ph != PH_NOLOCK && !lock_seen) begin
                m_ph  = PH_NOLOCK;
                m_age = 0;
            end else begin
                case (m_ph)
                    PH_NOLOCK: if (lock_seen) begin m_ph = PH_SETTLE; m_age = 0; end
                    PH_SETTLE: begin
                        m_age++;
                        if (m_age == L) begin m_ph = PH_DELAY; m_age = 0; end
                    end
                    PH_DELAY: begin
                        m_age++;
                        if (m_age == A) begin m_ph = PH_LIVE; m_age = 0; end
                    end
                    PH_LIVE: begin
                        if (se0_seen) begin
                            m_age++;
                            if (m_age == S) begin
                                m_ph  = PH_BUSRST;
                                m_age = 0;
                                if (m_resets < 255) m_resets++;
                            end
                        end else begin
                            m_age = 0;
                        end
                    end
                    PH_BUSRST: if (!se0_seen) begin m_ph = PH_RECOVER; m_age = 0; end
                    PH_RECOVER: begin
                        if (se0_seen) begin
                            m_ph  = PH_BUSRST;
                            m_age = 0;
                        end else begin
                            m_age++;
                            if (m_age == H) begin m_ph = PH_LIVE; m_age = 0; end
                        end
                    end
                    default: m_ph = PH_NOLOCK;
                endcase
            end
            m_lock_hist = {m_lock_hist[0], pll_lock};
            m_p_hist    = {m_p_hist[0], p_rx};
            m_n_hist    = {m_n_hist[0], n_rx};
        end
        e.cr  = (m_ph == PH_NOLOCK) || (m_ph == PH_SETTLE) ||
                (m_ph == PH_BUSRST) || (m_ph == PH_RECOVER);
        e.pu  = (m_ph == PH_LIVE) || (m_ph == PH_BUSRST) || (m_ph == PH_RECOVER);
        e.cnt = m_resets[7:0];
        sb_q.push_back(e);
    endtask

    // One clock: the model consumes the inputs sampled at this edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_edge(input logic [1:0] k, input int dly);
        ev_t ev;
        ev.kind = k;
        ev.at   = cyc + dly;
        ev_q.push_back(ev);
    endtask

    task automatic line_se0(input int n);
        p_rx = 1'b0; n_rx = 1'b0;
        ticks(n);
    endtask

    task automatic line_j(input int n);
        p_rx = 1'b1; n_rx = 1'b0;
        ticks(n);
    endtask

    task automatic edge_seen(input logic [1:0] k);
        ev_t ev;
        if (ev_q.size() > 0 && ev_q[0].kind == k) begin
            ev = ev_q.pop_front();
            checks++;
            if (cyc != ev.at) begin
                errors++;
                $display("FAIL edge%0d seen at cycle %0d, expected at cycle %0d", k, cyc, ev.at);
            end
        end
    endtask

    // Monitor: pops one expected output set per clock and times the edges.
    initial begin : monitor
        exp_t e;
        ev_t  ev;
        logic prev_cr;
        logic prev_pu;
        bit   armed;
        armed   = 1'b0;
        prev_cr = 1'b1;
        prev_pu = 1'b0;
        while (!done && cyc < 60000) begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({core_reset, pu_en, bus_reset_count} !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got cr=%b pu=%b count=%0d, expected cr=%b pu=%b count=%0d",
                             cyc, core_reset, pu_en, bus_reset_count, e.cr, e.pu, e.cnt);
                end
                if (armed) begin
                    if (!prev_cr && core_reset)  edge_seen(CR_RISE);
                    if (prev_cr && !core_reset)  edge_seen(CR_FALL);
                    if (!prev_pu && pu_en)       edge_seen(PU_RISE);
                    if (prev_pu && !pu_en)       edge_seen(PU_FALL);
                end
                armed   = 1'b1;
                prev_cr = core_reset;
                prev_pu = pu_en;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: stimulus still running at cycle %0d, limit 60000", cyc);
        end
        while (ev_q.size() > 0) begin
            ev = ev_q.pop_front();
            checks++;
            errors++;
            $display("FAIL edge%0d never seen, expected at cycle %0d", ev.kind, ev.at);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Stimulus
    initial begin : stimulus
        int r;
        int len;
        rst = 1'b1; pll_lock = 1'b0; p_rx = 1'b1; n_rx = 1'b0; tx_en = 1'b0;
        ticks(3);

        // Power-up
        rst = 1'b0; pll_lock = 1'b1;
        expect_edge(CR_FALL, 11);
        expect_edge(PU_RISE, 27);
        ticks(30);

        // Lock loss while attached
        pll_lock = 1'b0;
        expect_edge(CR_RISE, 3);
        expect_edge(PU_FALL, 3);
        ticks(10);

        // Lock glitch in the middle of the stable window
        pll_lock = 1'b1;
        ticks(6);
        pll_lock = 1'b0;
        ticks(3);
        pll_lock = 1'b1;
        expect_edge(CR_FALL, 11);
        expect_edge(PU_RISE, 27);
        ticks(30);

        // SE0 threshold: one short of the limit, then exactly the limit
        line_se0(S - 1);
        line_j(15);
        expect_edge(CR_RISE, 12);
        line_se0(S);
        expect_edge(CR_FALL, 7);
        line_j(15);

        // Long bus reset and release
        expect_edge(CR_RISE, 12);
        line_se0(50);
        expect_edge(CR_FALL, 7);
        line_j(15);

        // SE0 returning during the hold period
        expect_edge(CR_RISE, 12);
        line_se0(30);
        line_j(2);
        line_se0(20);
        expect_edge(CR_FALL, 7);
        line_j(15);

        // Own transmission masks SE0, then a sub-threshold run still passes
        tx_en = 1'b1;
        line_se0(40);
        line_j(3);
        tx_en = 1'b0;
        line_j(5);
        line_se0(S - 1);
        line_j(15);

        // Sync reset in the middle of a bus reset
        line_se0(20);
        rst = 1'b1;
        expect_edge(PU_FALL, 1);
        tick();
        rst = 1'b0; p_rx = 1'b1;
        expect_edge(CR_FALL, 11);
        expect_edge(PU_RISE, 27);
        ticks(30);

        // Counter saturation
        for (int i = 0; i < 258; i++) begin
            line_se0(S + 2);
            line_j(10);
        end

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: line_j(int'($urandom_range(1, 20)));
                4, 5, 6: begin
                    case ($urandom_range(0, 3))
                        0: len = S - 1;
                        1: len = S;
                        2: len = S + 1;
                        default: len = int'($urandom_range(1, 40));
                    endcase
                    line_se0(len);
                end
                7: begin
                    tx_en = 1'b1;
                    line_se0(int'($urandom_range(1, 30)));
                    line_j(int'($urandom_range(0, 3)));
                    tx_en = 1'b0;
                end
                8: begin
                    pll_lock = 1'b0;
                    ticks(int'($urandom_range(1, 5)));
                    pll_lock = 1'b1;
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1'b1;
                        tick();
                        rst = 1'b0;
                    end else begin
                        line_j(int'($urandom_range(1, 5)));
                    end
                end
            endcase
        end
        line_j(5);
        done = 1'b1;
    end

endmodule

// File: doc/usb_reset_ctrl.md
# usb_reset_ctrl

Reset and attach sequencer that sits directly upstream of `tinyfpga_bootloader` in the board top level. It drives the core's `reset` input and the USB D+ pull-up enable (`pin_pu`), both of which are currently tied constant. It holds the bootloader core in reset until the PLL output has been locked and stable, then connects the pull-up after a fixed delay. After attach it watches the received line state and re-resets the core when the host signals a USB bus reset (prolonged SE0).

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 4800: consecutive synchronized `pll_lock`-high cycles required before the core reset is released (100 us at 48 MHz).
- `ATTACH_DELAY_CYCLES`, default 48000: cycles from core reset release to pull-up enable (1 ms).
- `SE0_RESET_CYCLES`, default 120: consecutive SE0 cycles that count as a bus reset (2.5 us).
- `RESET_HOLD_CYCLES`, default 48: extra cycles of core reset after SE0 ends.

Ports:
- `clk_48mhz`, in, 1: the only clock (PLL output).
- `reset`, in, 1: synchronous, active-high.
- `pll_lock`, in, 1: PLL LOCK; asynchronous.
- `usb_p_rx`, in, 1: received D+; asynchronous.
- `usb_n_rx`, in, 1: received D-; asynchronous.
- `usb_tx_en`, in, 1: core transmit enable; synchronous to `clk_48mhz`.
- `core_reset`, out, 1: drives `tinyfpga_bootloader.reset`.
- `pu_en`, out, 1: drives `pin_pu`.
- `bus_reset_count`, out, 8: number of bus resets detected; saturating.

## Operation
- `pll_lock`, `usb_p_rx` and `usb_n_rx` each pass through a 2-flop synchronizer. All logic below uses the synchronized versions `lock_s`, `p_s` and `n_s`.
- `se0 = !p_s && !n_s && !usb_tx_en`.
- States and transitions:
  - WAIT_LOCK: `core_reset`=1, `pu_en`=0. Go to LOCK_STABLE when `lock_s`=1; the counter is cleared on entry.
  - LOCK_STABLE: `core_reset`=1, `pu_en`=0. The counter increments each cycle `lock_s`=1.
    - If `lock_s`=0, return to WAIT_LOCK.
    - When the counter reaches `LOCK_STABLE_CYCLES`-1 with `lock_s`=1, go to ATTACH_WAIT.
  - ATTACH_WAIT: `core_reset`=0, `pu_en`=0. Count to `ATTACH_DELAY_CYCLES`-1, then go to ATTACHED.
  - ATTACHED: `core_reset`=0, `pu_en`=1.
    - The SE0 counter increments while `se0`=1 and clears to 0 when `se0`=0.
    - When the counter reaches `SE0_RESET_CYCLES`-1 with `se0`=1, go to BUS_RESET and increment `bus_reset_count`. The count saturates at 255.
  - BUS_RESET: `core_reset`=1, `pu_en`=1. Remain while `se0`=1. On the first `se0`=0 cycle, go to HOLD.
  - HOLD: `core_reset`=1, `pu_en`=1. Count `RESET_HOLD_CYCLES`, then go to ATTACHED with the SE0 counter cleared. If `se0` returns to 1 during HOLD, go back to BUS_RESET without incrementing `bus_reset_count`.
- `lock_s`=0 in any state other than WAIT_LOCK forces WAIT_LOCK on the next cycle. This has priority over every other transition.
- `usb_tx_en`=1 masks SE0, so the core's own EOP never counts toward a bus reset.
- A single shared down/up counter is allowed. Its width is `$clog2` of the largest parameter value plus 1.
- `core_reset` and `pu_en` are registered outputs decoded from the next state, so they change in the same cycle as the state register.

## Timing
- Reset (`reset`=1 at a clock edge) puts the block in WAIT_LOCK with all counters at 0, `bus_reset_count`=0, `core_reset`=1 and `pu_en`=0. Synchronizer flops also reset to 0. This applies at any time, including mid-BUS_RESET or HOLD.
- `pll_lock` rising to `core_reset` falling: 2 synchronizer cycles + 1 cycle (WAIT_LOCK→LOCK_STABLE) + `LOCK_STABLE_CYCLES` cycles.
- `core_reset` falling to `pu_en` rising: exactly `ATTACH_DELAY_CYCLES` cycles.
- Start of line SE0 (at the pins) to `core_reset` rising: 2 + `SE0_RESET_CYCLES` cycles.
- End of line SE0 to `core_reset` falling: 2 + 1 + `RESET_HOLD_CYCLES` cycles.
- An SE0 run of `SE0_RESET_CYCLES`-1 cycles must not trigger a reset. A run of exactly `SE0_RESET_CYCLES` cycles must.
- Lock loss to `core_reset`=1 and `pu_en`=0: 2 synchronizer cycles + 1 cycle.

## Test plan
Directed tests use parameters LOCK=8, ATTACH=16, SE0=10, HOLD=4.
- Power-up: deassert `reset`, raise `pll_lock` at cycle 0 → `core_reset` falls at cycle 11, `pu_en` rises at cycle 27, `bus_reset_count`=0.
- Lock glitch: drop `pll_lock` for 3 cycles in the middle of LOCK_STABLE → the stable count restarts, and `core_reset` falls 11 cycles after `pll_lock` rises again.
- SE0 threshold: while ATTACHED, drive SE0 for 9 cycles → no `core_reset`. Then drive it for 10 cycles → `core_reset`=1 exactly 12 cycles after SE0 start, `bus_reset_count`=1.
- Bus reset release: hold SE0 for 50 cycles, then J state → `core_reset` falls 7 cycles after SE0 ends. Re-enter SE0 during HOLD → back to BUS_RESET with `bus_reset_count` unchanged.
- TX masking: hold `usb_tx_en`=1 with pins at SE0 for 40 cycles → no reset, and the SE0 counter reads 0 after `usb_tx_en` falls.
- Lock loss and sync reset: drop `pll_lock` while ATTACHED → `core_reset`=1 and `pu_en`=0 after 3 cycles. Separately, assert `reset` mid-BUS_RESET → all outputs return to their reset values on the next edge, including `bus_reset_count`=0.
